// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program-counter sequencer for the multi-core datapath.
// Each non-stalled cycle the shared PC loads either PC+4 or the jump target of one
// requesting core, chosen by fixed-priority (lowest index) or round-robin arbitration.
// A registered one-hot grant tells each core whether its jump was taken.
//
// Optional feature macro: PC_CONFLICT_CNT_EN adds a saturating 16-bit count of
// accepted cycles that had two or more competing requests.
//
// Ports:
//   clk            - sole clock, rising edge
//   reset          - synchronous, active-high
//   stall          - hold PC, accept nothing
//   core_pcs       - packed jump targets, core i at [i*WIDTH +: WIDTH]
//   core_controls  - jump requests, bit i per core
//   pc             - current PC (registered)
//   jump_grant     - one-hot core whose target is now in pc (registered)
//   jump_taken     - OR of jump_grant (registered)
//   conflict_count - conflict counter (PC_CONFLICT_CNT_EN only)
module pc_sequencer #(
  parameter int unsigned     CORES       = 4,
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter bit              ROUND_ROBIN = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [CORES*WIDTH-1:0] core_pcs,
  input  logic [CORES-1:0]       core_controls,
  output logic [WIDTH-1:0]       pc,
  output logic [CORES-1:0]       jump_grant,
`ifdef PC_CONFLICT_CNT_EN
  output logic                   jump_taken,
  output logic [15:0]            conflict_count
`else
  output logic                   jump_taken
`endif
);

  localparam int unsigned PW = (CORES > 1) ? $clog2(CORES) : 1;

  logic [WIDTH-1:0] r_pc;
  logic [CORES-1:0] r_grant;
  logic             r_taken;
  logic [PW-1:0]    r_ptr;

  logic [CORES-1:0] w_req;
  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_ptr_next;
  logic [WIDTH-1:0] w_target;

  // A core granted this cycle is masked so it cannot be re-accepted back to back.
  assign w_req = core_controls & ~r_grant;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < CORES; k++) begin
      int unsigned idx;
      idx = ROUND_ROBIN ? ((int'(r_ptr) + k) % CORES) : k;
      if (!w_found && w_req[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  assign w_ptr_next = (int'(w_win) == int'(CORES) - 1) ? '0 : w_win + PW'(1);
  assign w_target   = core_pcs[int'(w_win)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_grant <= '0;
      r_taken <= 1'b0;
      r_ptr   <= '0;
    end else if (stall) begin
      r_grant <= '0;
      r_taken <= 1'b0;
    end else if (w_found) begin
      r_pc    <= w_target;
      r_grant <= CORES'(1) << w_win;
      r_taken <= 1'b1;
      if (ROUND_ROBIN) begin
        r_ptr <= w_ptr_next;
      end
    end else begin
      r_pc    <= r_pc + WIDTH'(4);
      r_grant <= '0;
      r_taken <= 1'b0;
    end
  end

`ifdef PC_CONFLICT_CNT_EN
  logic [15:0] r_conflicts;
  logic        w_multi;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(w_req & (w_req - CORES'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflicts <= '0;
    end else if (!stall && w_multi && (r_conflicts != 16'hFFFF)) begin
      r_conflicts <= r_conflicts + 16'd1;
    end
  end

  assign conflict_count = r_conflicts;
`endif

  assign pc         = r_pc;
  assign jump_grant = r_grant;
  assign jump_taken = r_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one fixed-priority and one round-robin instance
// share clock, reset, stall and targets; each has its own request vector.
module tb_pc_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic [127:0] core_pcs;
  logic [3:0]   ctl_fix, ctl_rr;
  logic [31:0]  pc_fix, pc_rr;
  logic [3:0]   gnt_fix, gnt_rr;
  logic         tk_fix, tk_rr;
`ifdef PC_CONFLICT_CNT_EN
  logic [15:0]  cc_fix, cc_rr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.CORES(4), .WIDTH(32), .RESET_PC(32'h0), .ROUND_ROBIN(1'b0)) u_fix (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .core_pcs      (core_pcs),
    .core_controls (ctl_fix),
    .pc            (pc_fix),
    .jump_grant    (gnt_fix),
`ifdef PC_CONFLICT_CNT_EN
    .jump_taken    (tk_fix),
    .conflict_count(cc_fix)
`else
    .jump_taken    (tk_fix)
`endif
  );

  pc_sequencer #(.CORES(4), .WIDTH(32), .RESET_PC(32'h0), .ROUND_ROBIN(1'b1)) u_rr (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .core_pcs      (core_pcs),
    .core_controls (ctl_rr),
    .pc            (pc_rr),
    .jump_grant    (gnt_rr),
`ifdef PC_CONFLICT_CNT_EN
    .jump_taken    (tk_rr),
    .conflict_count(cc_rr)
`else
    .jump_taken    (tk_rr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fix(input string tag, input logic [31:0] epc, input logic [3:0] egnt);
    chk({tag, ".pc"}, 64'(pc_fix), 64'(epc));
    chk({tag, ".gnt"}, 64'(gnt_fix), 64'(egnt));
    chk({tag, ".taken"}, 64'(tk_fix), 64'(|egnt));
  endtask

  task automatic chk_rr(input string tag, input logic [31:0] epc, input logic [3:0] egnt);
    chk({tag, ".pc"}, 64'(pc_rr), 64'(epc));
    chk({tag, ".gnt"}, 64'(gnt_rr), 64'(egnt));
    chk({tag, ".taken"}, 64'(tk_rr), 64'(|egnt));
  endtask

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    ctl_fix  = 4'b0000;
    ctl_rr   = 4'b0000;
    core_pcs = {32'd14, 32'd24, 32'd36, 32'd64};

    // Reset, then free-run by 4.
    step();
    chk_fix("rst_fix", 32'h0, 4'b0000);
    chk_rr("rst_rr", 32'h0, 4'b0000);
    reset = 1'b0;
    step(); chk_fix("inc1", 32'h4, 4'b0000);
    step(); chk_fix("inc2", 32'h8, 4'b0000);
    step(); chk_fix("inc3", 32'hC, 4'b0000);

    // Single jump from core 2.
    ctl_fix = 4'b0100;
    step(); chk_fix("jmp_c2", 32'd24, 4'b0100);
    ctl_fix = 4'b0000;
    step(); chk_fix("after_jmp", 32'd28, 4'b0000);

    // Cores 1 and 2 collide; core 2 keeps requesting and wins next.
    ctl_fix = 4'b0110;
    step(); chk_fix("coll_c1", 32'd36, 4'b0010);
    ctl_fix = 4'b0100;
    step(); chk_fix("coll_c2", 32'd24, 4'b0100);
    ctl_fix = 4'b0000;
    step(); chk_fix("coll_done", 32'd28, 4'b0000);

    // Core 0 holding its request: granted, masked one cycle, granted again.
    ctl_fix = 4'b0001;
    step(); chk_fix("hold_g1", 32'd64, 4'b0001);
    step(); chk_fix("hold_gap", 32'd68, 4'b0000);
    step(); chk_fix("hold_g2", 32'd64, 4'b0001);
    ctl_fix = 4'b0000;
    step(); chk_fix("hold_end", 32'd68, 4'b0000);

    // Stall with core 0 requesting.
    stall   = 1'b1;
    ctl_fix = 4'b0001;
    step(); chk_fix("stall1", 32'd68, 4'b0000);
    step(); chk_fix("stall2", 32'd68, 4'b0000);
    stall = 1'b0;
    step(); chk_fix("unstall", 32'd64, 4'b0001);
    ctl_fix = 4'b0000;

    // Round-robin rotation with all four cores requesting.
    ctl_rr = 4'b1111;
    step(); chk_rr("rr0", 32'd64, 4'b0001);
    step(); chk_rr("rr1", 32'd36, 4'b0010);
    step(); chk_rr("rr2", 32'd24, 4'b0100);
    step(); chk_rr("rr3", 32'd14, 4'b1000);
    step(); chk_rr("rr4", 32'd64, 4'b0001);
    ctl_rr = 4'b0000;
`ifdef PC_CONFLICT_CNT_EN
    chk("cc_fix", 64'(cc_fix), 64'd1);
    chk("cc_rr", 64'(cc_rr), 64'd5);
`endif

    // PC wrap.
    core_pcs[31:0] = 32'hFFFF_FFFC;
    ctl_fix = 4'b0001;
    step(); chk_fix("wrap_jmp", 32'hFFFF_FFFC, 4'b0001);
    ctl_fix = 4'b0000;
    step(); chk_fix("wrap0", 32'h0, 4'b0000);
    step(); chk_fix("wrap4", 32'h4, 4'b0000);

    // Reset in a grant cycle; rr pointer is 1 here so core 1 wins first.
    ctl_fix = 4'b0001;
    ctl_rr  = 4'b1111;
    step();
    chk_fix("pre_rst_fix", 32'hFFFF_FFFC, 4'b0001);
    chk_rr("pre_rst_rr", 32'd36, 4'b0010);
    reset = 1'b1;
    step();
    chk_fix("mid_rst_fix", 32'h0, 4'b0000);
    chk_rr("mid_rst_rr", 32'h0, 4'b0000);
`ifdef PC_CONFLICT_CNT_EN
    chk("cc_rst", 64'(cc_rr), 64'd0);
`endif
    reset   = 1'b0;
    ctl_fix = 4'b0000;
    step();
    chk_fix("post_rst_fix", 32'h4, 4'b0000);
    chk_rr("post_rst_ptr0", 32'hFFFF_FFFC, 4'b0001);
`ifdef PC_CONFLICT_CNT_EN
    chk("cc_post", 64'(cc_rr), 64'd1);
`endif
    ctl_rr = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
